mnist_image_loader: RTL and testbench
=====================================

MNIST_IMAGE_LOADER -- requirements
Module: mnist_image_loader

Interface
REQ-001 SHALL have parameter NPIX, default 784, meaning pixels per frame (28x28).
REQ-002 SHALL have parameter HOLD_CYCLES, default 16, meaning cycles the image is held stable for the downstream classifier (range 1..65535).
REQ-003 SHALL have port clk, input, 1, sole clock; all logic rising-edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port pix_data, input, 8, unsigned grayscale pixel in raster order.
REQ-006 SHALL have port pix_valid, input, 1, pix_data valid this cycle.
REQ-007 SHALL have port pix_sof, input, 1, qualifies the first pixel of a frame; meaningful only with pix_valid.
REQ-008 SHALL have port pix_ready, output, 1, loader accepts a pixel this cycle.
REQ-009 SHALL have port image, output, unpacked array [0:NPIX-1] of signed 9-bit, the frame presented to the classifier.
REQ-010 SHALL have port image_valid, output, 1, image is complete and stable.
REQ-011 SHALL have port err_restart, output, 1, one-cycle pulse: frame aborted by an early pix_sof.
REQ-012 SHALL have port frame_cnt, output, 16, count of completed frames.

Function
REQ-013 SHALL accept a pixel only on a cycle where pix_valid=1 and pix_ready=1 and rst=0.
REQ-014 SHALL store each pixel zero-extended to signed 9 bits (values 0..255, bit 8 always 0).
REQ-015 SHALL implement states IDLE, FILL, HOLD; pix_ready = 1 in IDLE and FILL, 0 in HOLD (decoded from registered state).
REQ-016 IDLE: an accepted pixel with pix_sof=1 SHALL write image[0], set index to 1, go to FILL; accepted pixels with pix_sof=0 SHALL be discarded.
REQ-017 FILL: an accepted pixel with pix_sof=0 SHALL write image[index] and increment index.
REQ-018 FILL: an accepted pixel with pix_sof=1 SHALL write image[0], set index to 1, stay in FILL, pulse err_restart the next cycle; previously written entries are not cleared.
REQ-019 When the pixel at index NPIX-1 is accepted, the state SHALL become HOLD on the next edge; image_valid SHALL be 1 from that cycle for exactly HOLD_CYCLES cycles.
REQ-020 On entering HOLD, frame_cnt SHALL increment by 1, wrapping 0xFFFF -> 0x0000.
REQ-021 After HOLD_CYCLES cycles in HOLD, the state SHALL return to IDLE; image_valid falls and pix_ready rises on the same edge.
REQ-022 image SHALL not change while image_valid=1; outside HOLD it reflects the partially filled frame and SHALL be ignored downstream.
REQ-023 Latency: last pixel accepted in cycle t -> image_valid=1 in cycle t+1; minimum frame period NPIX+HOLD_CYCLES cycles.
REQ-024 pix_valid/pix_sof during HOLD SHALL have no effect (pixels not accepted, no error).
REQ-025 The hold counter SHALL be 16 bits; the pixel index SHALL be $clog2(NPIX) bits and never exceed NPIX-1.

Reset
REQ-026 On rst=1 at a clock edge: state IDLE, index 0, hold counter 0, image all zeros, image_valid 0, err_restart 0, frame_cnt 0.
REQ-027 Reset mid-FILL or mid-HOLD SHALL abandon the frame with no err_restart pulse and no frame_cnt increment; pixels presented while rst=1 are not accepted.

Structure
REQ-028 Package cnn_pkg SHALL hold NPIX_MNIST=784, IMG_DIM=28, PIX_W=9, and the loader state enum type.
REQ-029 The block SHALL be a single module with no sub-modules; the pixel buffer is a flop array with one indexed write port.

Verification
REQ-030 Reset then 784 pixels (value = index mod 256, sof on first, valid every cycle) -> image[k]=k mod 256, image_valid high cycle 785 for 16 cycles, frame_cnt=1.
REQ-031 Same frame with pix_valid toggled 50% random -> identical image contents; image_valid one cycle after the 784th accepted pixel.
REQ-032 sof at pixel 300 then a full 784-pixel frame -> err_restart single pulse, image holds second frame, frame_cnt=1.
REQ-033 Pixels presented during HOLD and pixels without sof in IDLE -> ignored; image unchanged, no err_restart.
REQ-034 rst asserted at pixel 500 then full frame -> outputs zero after reset, frame completes normally, frame_cnt=1.
REQ-035 Pixel value 255 at index 783 -> image[783]=+255 (9'h0FF), never negative.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared constants and types for the MNIST front end: frame geometry,
// pixel width and the image loader state encoding.
package cnn_pkg;

  localparam int IMG_DIM     = 28;
  localparam int NPIX_MNIST  = IMG_DIM * IMG_DIM;
  localparam int PIX_W       = 9;
  localparam int HOLD_W      = 16;
  localparam int FRAME_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HOLD = 2'd2
  } ld_state_e;

  // Raw grayscale is unsigned; the classifier wants signed operands, so the
  // sign bit is forced to zero to keep 255 positive.
  function automatic logic [PIX_W-1:0] pix_extend(input logic [7:0] raw);
    return {1'b0, raw};
  endfunction

endpackage

// File: rtl/mnist_image_loader.sv
// Collects a raster-ordered grayscale frame into a flop buffer and holds it
// stable for a fixed number of cycles while the classifier consumes it.
//
// state | meaning
// IDLE  | waiting for a start-of-frame pixel, everything else dropped
// FILL  | storing pixels at the running index
// HOLD  | frame complete, image frozen, input back-pressured
module mnist_image_loader
  import cnn_pkg::*;
#(
  parameter int NPIX        = NPIX_MNIST,
  parameter int HOLD_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              pix_data,
  input  logic                    pix_valid,
  input  logic                    pix_sof,
  output logic                    pix_ready,
  output logic signed [PIX_W-1:0] image [0:NPIX-1],
  output logic                    image_valid,
  output logic                    err_restart,
  output logic [FRAME_CNT_W-1:0]  frame_cnt
);

  localparam int IDX_W = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NPIX - 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

  ld_state_e          state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               err_d;
  logic               accept;
  logic               wr_en;
  logic [IDX_W-1:0]   wr_idx;
  logic               sof_is_last;

  assign pix_ready   = (state_q != HOLD);
  assign image_valid = (state_q == HOLD);
  assign accept      = pix_valid & pix_ready;
  // Only true for a one-pixel frame, where the sof pixel also completes it.
  assign sof_is_last = (LAST_IDX == '0);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    err_d   = 1'b0;
    wr_en   = 1'b0;
    wr_idx  = '0;

    unique case (state_q)
      IDLE: begin
        if (accept && pix_sof) begin
          wr_en = 1'b1;
          if (sof_is_last) begin
            state_d = HOLD;
            hold_d  = HOLD_LOAD;
            idx_d   = '0;
          end else begin
            state_d = FILL;
            idx_d   = IDX_W'(1);
          end
        end
      end

      FILL: begin
        if (accept) begin
          wr_en = 1'b1;
          if (pix_sof) begin
            // Restart in place: stale entries past the new index stay until overwritten.
            err_d = 1'b1;
            if (sof_is_last) begin
              state_d = HOLD;
              hold_d  = HOLD_LOAD;
              idx_d   = '0;
            end else begin
              idx_d = IDX_W'(1);
            end
          end else begin
            wr_idx = idx_q;
            if (idx_q == LAST_IDX) begin
              state_d = HOLD;
              hold_d  = HOLD_LOAD;
              idx_d   = '0;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end
        end
      end

      HOLD: begin
        if (hold_q == '0) begin
          state_d = IDLE;
        end else begin
          hold_d = hold_q - HOLD_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        idx_d   = '0;
        hold_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      hold_q      <= '0;
      err_restart <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      hold_q      <= hold_d;
      err_restart <= err_d;
      if (state_d == HOLD && state_q != HOLD) begin
        frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NPIX; i++) begin
        image[i] <= '0;
      end
    end else if (wr_en) begin
      image[wr_idx] <= pix_extend(pix_data);
    end
  end

endmodule

// File: tb/tb_mnist_image_loader.sv
// Directed bench for the MNIST image loader: full frames, gappy valid,
// early restart, ignored input, mid-frame reset and the 255 boundary pixel.
module tb_mnist_image_loader;
  import cnn_pkg::*;

  localparam int NPIX = 784;
  localparam int HOLD = 16;

  logic                    clk;
  logic                    rst;
  logic [7:0]              pix_data;
  logic                    pix_valid;
  logic                    pix_sof;
  logic                    pix_ready;
  logic signed [PIX_W-1:0] image [0:NPIX-1];
  logic                    image_valid;
  logic                    err_restart;
  logic [15:0]             frame_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int err_seen = 0;

  mnist_image_loader #(.NPIX(NPIX), .HOLD_CYCLES(HOLD)) dut (
    .clk        (clk),
    .rst        (rst),
    .pix_data   (pix_data),
    .pix_valid  (pix_valid),
    .pix_sof    (pix_sof),
    .pix_ready  (pix_ready),
    .image      (image),
    .image_valid(image_valid),
    .err_restart(err_restart),
    .frame_cnt  (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (err_restart === 1'b1) err_seen++;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int d, input bit s);
    pix_valid = 1'b1;
    pix_data  = 8'(d);
    pix_sof   = s;
    tick();
  endtask

  task automatic quiet();
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    pix_data  = 8'h00;
  endtask

  task automatic do_reset();
    quiet();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Counts image_valid cycles; optionally keeps junk sof pixels on the input.
  task automatic count_hold(input bit junk, output int n);
    n = 0;
    if (junk) begin
      pix_valid = 1'b1;
      pix_sof   = 1'b1;
      pix_data  = 8'h55;
    end
    while (image_valid && n < HOLD + 8) begin
      n++;
      tick();
    end
    quiet();
  endtask

  task automatic check_frame(input string tag, input int off, input int last_val);
    int bad;
    int e;
    bad = 0;
    for (int k = 0; k < NPIX; k++) begin
      e = (k + off) % 256;
      if (k == NPIX - 1 && last_val >= 0) e = last_val;
      if (int'(image[k]) != e) bad++;
    end
    check(tag, bad, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int k;
    int cyc;
    int early;
    int err_base;

    rst = 1'b0;
    quiet();
    @(posedge clk);
    #1;

    // Reset state and a back-to-back frame
    do_reset();
    check("rst_valid", int'(image_valid), 0);
    check("rst_ready", int'(pix_ready), 1);
    check("rst_err", int'(err_restart), 0);
    check("rst_fcnt", int'(frame_cnt), 0);
    check("rst_img0", int'(image[0]), 0);
    for (int i = 0; i < NPIX; i++) begin
      send(i % 256, i == 0);
      if (i == NPIX - 2) check("valid_before_last", int'(image_valid), 0);
    end
    check("valid_after_last", int'(image_valid), 1);
    check("ready_in_hold", int'(pix_ready), 0);
    check("fcnt_frame1", int'(frame_cnt), 1);
    quiet();
    count_hold(1'b0, n);
    check("hold_len", n, HOLD);
    check("ready_after_hold", int'(pix_ready), 1);
    check_frame("img_frame1", 0, -1);
    check("img_783", int'(image[783]), 15);

    // Same frame with valid toggled randomly
    do_reset();
    k = 0;
    cyc = 0;
    early = 0;
    while (k < NPIX && cyc < 5000) begin
      pix_valid = 1'($urandom_range(0, 1));
      pix_data  = 8'(k % 256);
      pix_sof   = (k == 0);
      if (pix_valid && pix_ready) k++;
      tick();
      cyc++;
      if (k < NPIX && image_valid) early++;
    end
    quiet();
    check("rand_done", k, NPIX);
    check("rand_early_valid", early, 0);
    check("rand_valid_latency", int'(image_valid), 1);
    check_frame("img_rand", 0, -1);
    check("fcnt_rand", int'(frame_cnt), 1);
    count_hold(1'b0, n);
    check("hold_len_rand", n, HOLD);

    // Early sof restart, then junk during HOLD and sof-less pixels in IDLE
    do_reset();
    err_base = err_seen;
    for (int i = 0; i < 300; i++) send(i % 256, i == 0);
    check("no_err_before", int'(err_restart), 0);
    send(100, 1'b1);
    check("err_pulse", int'(err_restart), 1);
    for (int i = 1; i < NPIX; i++) begin
      send((i + 100) % 256, 1'b0);
      if (i == 1) check("err_drop", int'(err_restart), 0);
    end
    check("valid_restart", int'(image_valid), 1);
    check("fcnt_restart", int'(frame_cnt), 1);
    count_hold(1'b1, n);
    check("hold_len_junk", n, HOLD);
    check_frame("img_restart", 100, -1);
    for (int i = 0; i < 10; i++) send(8'hAA, 1'b0);
    quiet();
    tick();
    check("idle_nosof_valid", int'(image_valid), 0);
    check_frame("img_ignored", 100, -1);
    check("fcnt_ignored", int'(frame_cnt), 1);
    check("err_count_restart", err_seen - err_base, 1);

    // Reset in the middle of a frame, then a frame ending in 255
    do_reset();
    err_base = err_seen;
    for (int i = 0; i < 500; i++) send(8'hFF, i == 0);
    rst       = 1'b1;
    pix_valid = 1'b1;
    pix_sof   = 1'b1;
    pix_data  = 8'h77;
    tick();
    rst = 1'b0;
    quiet();
    tick();
    check("midrst_img0", int'(image[0]), 0);
    check("midrst_img499", int'(image[499]), 0);
    check("midrst_valid", int'(image_valid), 0);
    check("midrst_fcnt", int'(frame_cnt), 0);
    for (int i = 0; i < NPIX; i++) send((i == NPIX - 1) ? 255 : i % 256, i == 0);
    quiet();
    check("midrst_frame_valid", int'(image_valid), 1);
    check("midrst_frame_fcnt", int'(frame_cnt), 1);
    check("img_783_255", int'(image[783]), 255);
    check("img_783_sign", int'(image[783][PIX_W-1]), 0);
    check_frame("img_after_rst", 0, 255);
    count_hold(1'b0, n);
    check("hold_len_final", n, HOLD);
    check("err_count_rst", err_seen - err_base, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
